tiny_evg: RTL
=============

Name: tiny_evg

Overview:
Minimal MRF-compatible event generator: the transmit end of the event link consumed by the tiny event receiver. Serialises time-of-day (shift-zero/shift-one events 0x70/0x71, then seconds marker 0x7D), user event codes and the distributed data bus into 16-bit words plus K flags, one word per evrTxClk. Sits ahead of the transceiver TX datapath.

Parameters:
SECONDS_WIDTH, 32, width of seconds counter and number of shift events per second
SHIFT_SPACING, 8, cycles between successive shift events (min 2)
COMMA_INTERVAL, 4, idle slots between K28.5 commas (min 1)
HEARTBEAT_PERIOD, 125000000, cycles between heartbeat events (optional feature only)

Ports:
evrTxClk  in  1  event link transmit clock; sole clock
evrTxReset  in  1  asynchronous, active-high reset
ppsIn  in  1  pulse-per-second, synchronous to evrTxClk; rising edge triggers marker
secondsIn  in  SECONDS_WIDTH  seconds value to load
secondsLoad  in  1  strobe: load secondsIn into seconds counter
evRequestCode  in  8  user event code
evRequestValid  in  1  user event request
evRequestReady  out  1  holding register empty
distributedDataBus  in  8  sent on upper byte
evrTxWord  out  16  {dbus byte, event byte}
evrTxCharIsK  out  2  K flags; bit 1 always 0
seconds  out  SECONDS_WIDTH  seconds value of last marker sent
shiftOverrun  out  1  one-cycle pulse: marker sent before all shift bits sent
reservedDropped  out  1  one-cycle pulse: user code 0x00/0x70/0x71/0x7D discarded

Behaviour:
- Reset: evrTxWord=16'h00BC, evrTxCharIsK=2'b01, seconds=0, evRequestReady=1, pulses 0, FSM=WAIT, holding reg empty, ppsIn edge register=1 (no spurious edge out of reset).
- All outputs registered; event chosen in cycle t appears on evrTxWord at t+1.
- Upper byte: distributedDataBus registered each cycle, charIsK[1]=0.
- Low-byte priority per slot: (1) marker 0x7D, (2) shift event, (3) heartbeat (optional), (4) user event, (5) idle.
- Marker: ppsIn rising edge in cycle t -> 0x7D, K=0 at t+1; seconds <= nextSeconds. Marker never delayed.
- nextSeconds = seconds+1 mod 2^SECONDS_WIDTH, or secondsIn if secondsLoad seen since last marker (secondsLoad latched; latch cleared by marker; load in same cycle as edge applies to that marker).
- FSM WAIT: after marker -> SHIFT, bitIdx=SECONDS_WIDTH-1, spacing counter=SHIFT_SPACING-1.
- SHIFT: on spacing counter 0 emit 0x70|bit (value to be marked at next PPS = seconds+1 or latched load, MSB first), reload counter, decrement bitIdx; after bit 0 -> DONE. Shift slot pre-empted only by marker.
- DONE: wait for PPS edge -> marker -> SHIFT.
- PPS edge while in SHIFT: marker still sent, shiftOverrun pulse same cycle as marker on output, sequence restarts for new second.
- Out of reset FSM=WAIT: first PPS sends marker with no prior shifts (receiver increments; expected).
- User handshake: transfer when evRequestValid&&evRequestReady; ready deasserts next cycle until held code sent. Held code sent in first slot with no higher-priority event. Reserved codes: accepted, not stored, reservedDropped pulses next cycle, ready stays 1.
- Idle: counter of consecutive idle slots; slot where counter==COMMA_INTERVAL -> 0xBC, K=1, counter cleared; else 0x00, K=0. Non-idle slots do not reset counter.
- Reset mid-sequence: abort immediately to reset values; held user event lost.

Optional Feature:
TINY_EVG_HEARTBEAT_EN: defined -> free-running counter emits 0x7A every HEARTBEAT_PERIOD cycles at priority (3); if pre-empted, stays pending until sent, at most one pending. Undefined -> no counter, 0x7A sent only as user code.

Test Plan:
- Reset, no stimulus -> low byte pattern 00,00,00,00,BC repeating (COMMA_INTERVAL=4), charIsK[0]=1 only on BC.
- secondsLoad with 0x12345678, PPS edge -> 7D, seconds=0x12345678; then 32 shifts every 8 cycles encoding 0x12345679 MSB first; next PPS -> seconds=0x12345679; tiny event receiver model timestamp seconds=0x12345679, valid.
- PPS edge 100 cycles after marker (mid-shift) -> 7D sent next cycle, shiftOverrun pulses once, shift restarts at bit 31.
- User code 0x2A presented in same cycle as a due shift slot -> shift first, 0x2A next slot; ready low between acceptance and emission.
- User code 0x7D -> never emitted, reservedDropped pulses once, ready stays 1.
- distributedDataBus=0xA5 -> evrTxWord[15:8]=0xA5 one cycle later regardless of low-byte content.

Source files
------------

// File: rtl/tiny_evg_if.sv
// User event request handshake and distributed data bus between an event source and tiny_evg.
// The master side presents codes and the dbus byte; tiny_evg is the slave.
`timescale 1ns/1ps
interface tiny_evg_if;
    logic [7:0] evRequestCode;
    logic       evRequestValid;
    logic       evRequestReady;
    logic [7:0] distributedDataBus;

    modport master (
        output evRequestCode,
        output evRequestValid,
        output distributedDataBus,
        input  evRequestReady
    );

    modport slave (
        input  evRequestCode,
        input  evRequestValid,
        input  distributedDataBus,
        output evRequestReady
    );
endinterface

// File: rtl/tiny_evg.sv
// Minimal MRF-style event generator: markers, time-of-day shift events, user codes and dbus into 16-bit link words.
// Optional heartbeat event 0x7A is enabled by defining TINY_EVG_HEARTBEAT_EN.
`timescale 1ns/1ps
module tiny_evg #(
    parameter int SECONDS_WIDTH    = 32,
    parameter int SHIFT_SPACING    = 8,
    parameter int COMMA_INTERVAL   = 4,
    parameter int HEARTBEAT_PERIOD = 125000000
) (
    input  logic                     evrTxClk,
    input  logic                     evrTxReset,
    input  logic                     ppsIn,
    input  logic [SECONDS_WIDTH-1:0] secondsIn,
    input  logic                     secondsLoad,
    tiny_evg_if.slave                evReq,
    output logic [15:0]              evrTxWord,
    output logic [1:0]               evrTxCharIsK,
    output logic [SECONDS_WIDTH-1:0] seconds,
    output logic                     shiftOverrun,
    output logic                     reservedDropped
);

    localparam int BIT_W  = (SECONDS_WIDTH > 1) ? $clog2(SECONDS_WIDTH) : 1;
    localparam int SPC_W  = (SHIFT_SPACING > 2) ? $clog2(SHIFT_SPACING) : 1;
    localparam int IDLE_W = $clog2(COMMA_INTERVAL + 1);

    localparam logic [BIT_W-1:0]  BIT_TOP  = BIT_W'(SECONDS_WIDTH - 1);
    localparam logic [SPC_W-1:0]  SPC_TOP  = SPC_W'(SHIFT_SPACING - 1);
    localparam logic [IDLE_W-1:0] IDLE_TOP = IDLE_W'(COMMA_INTERVAL);

    localparam logic [7:0] CODE_IDLE   = 8'h00;
    localparam logic [7:0] CODE_SHIFT0 = 8'h70;
    localparam logic [7:0] CODE_SHIFT1 = 8'h71;
    localparam logic [7:0] CODE_MARKER = 8'h7D;
    localparam logic [7:0] CODE_HEART  = 8'h7A;
    localparam logic [7:0] CODE_COMMA  = 8'hBC;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SHIFT,
        ST_DONE
    } evgState_t;

    evgState_t                state;
    logic [BIT_W-1:0]         bitIdx;
    logic [SPC_W-1:0]         spacing;
    logic                     ppsPrev;
    logic                     loadPending;
    logic [SECONDS_WIDTH-1:0] loadValue;
    logic                     holdValid;
    logic [7:0]               holdCode;
    logic                     readyReg;
    logic [IDLE_W-1:0]        idleCount;

    logic                     ppsEdge;
    logic                     shiftDue;
    logic                     hbSend;
    logic                     userSend;
    logic                     idleSlot;
    logic                     accept;
    logic                     reservedCode;
    logic [SECONDS_WIDTH-1:0] nextSeconds;
    logic [7:0]               lowByte;
    logic                     lowIsK;

    assign evReq.evRequestReady = readyReg;

`ifdef TINY_EVG_HEARTBEAT_EN
    localparam int HB_W = (HEARTBEAT_PERIOD > 2) ? $clog2(HEARTBEAT_PERIOD) : 1;
    localparam logic [HB_W-1:0] HB_TOP = HB_W'(HEARTBEAT_PERIOD - 1);

    logic [HB_W-1:0] hbCount;
    logic            hbPending;

    // Free-running period counter; a tick that lands while one heartbeat is still pending merges with it.
    always_ff @(posedge evrTxClk or posedge evrTxReset) begin
        if (evrTxReset) begin
            hbCount   <= '0;
            hbPending <= 1'b0;
        end else if (hbCount == HB_TOP) begin
            hbCount   <= '0;
            hbPending <= 1'b1;
        end else begin
            hbCount <= hbCount + 1'b1;
            if (hbSend) begin
                hbPending <= 1'b0;
            end
        end
    end

    assign hbSend = hbPending && !ppsEdge && !shiftDue;
`else
    // Without the heartbeat, the period parameter has no effect and the slot never fires.
    assign hbSend = (HEARTBEAT_PERIOD < 0);
`endif

    always_comb begin
        ppsEdge      = ppsIn && !ppsPrev;
        shiftDue     = (state == ST_SHIFT) && (spacing == '0) && !ppsEdge;
        userSend     = holdValid && !ppsEdge && !shiftDue && !hbSend;
        idleSlot     = !ppsEdge && !shiftDue && !hbSend && !userSend;
        accept       = evReq.evRequestValid && readyReg;
        reservedCode = (evReq.evRequestCode == CODE_IDLE)   ||
                       (evReq.evRequestCode == CODE_SHIFT0) ||
                       (evReq.evRequestCode == CODE_SHIFT1) ||
                       (evReq.evRequestCode == CODE_MARKER);

        if (secondsLoad) begin
            nextSeconds = secondsIn;
        end else if (loadPending) begin
            nextSeconds = loadValue;
        end else begin
            nextSeconds = seconds + SECONDS_WIDTH'(1);
        end

        lowIsK = 1'b0;
        if (ppsEdge) begin
            lowByte = CODE_MARKER;
        end else if (shiftDue) begin
            lowByte = nextSeconds[bitIdx] ? CODE_SHIFT1 : CODE_SHIFT0;
        end else if (hbSend) begin
            lowByte = CODE_HEART;
        end else if (userSend) begin
            lowByte = holdCode;
        end else if (idleCount == IDLE_TOP) begin
            lowByte = CODE_COMMA;
            lowIsK  = 1'b1;
        end else begin
            lowByte = CODE_IDLE;
        end
    end

    // Slot sequencing, time-of-day state and the user holding register all advance on the same edge.
    always_ff @(posedge evrTxClk or posedge evrTxReset) begin
        if (evrTxReset) begin
            state           <= ST_WAIT;
            bitIdx          <= BIT_TOP;
            spacing         <= SPC_TOP;
            ppsPrev         <= 1'b1;
            loadPending     <= 1'b0;
            loadValue       <= '0;
            holdValid       <= 1'b0;
            holdCode        <= 8'h00;
            readyReg        <= 1'b1;
            idleCount       <= '0;
            evrTxWord       <= 16'h00BC;
            evrTxCharIsK    <= 2'b01;
            seconds         <= '0;
            shiftOverrun    <= 1'b0;
            reservedDropped <= 1'b0;
        end else begin
            ppsPrev         <= ppsIn;
            evrTxWord       <= {evReq.distributedDataBus, lowByte};
            evrTxCharIsK    <= {1'b0, lowIsK};
            shiftOverrun    <= ppsEdge && (state == ST_SHIFT);
            reservedDropped <= accept && reservedCode;

            if (ppsEdge) begin
                seconds     <= nextSeconds;
                loadPending <= 1'b0;
            end else if (secondsLoad) begin
                loadPending <= 1'b1;
                loadValue   <= secondsIn;
            end

            if (idleSlot) begin
                idleCount <= (idleCount == IDLE_TOP) ? '0 : idleCount + 1'b1;
            end

            if (userSend) begin
                holdValid <= 1'b0;
                readyReg  <= 1'b1;
            end else if (accept && !reservedCode) begin
                holdValid <= 1'b1;
                holdCode  <= evReq.evRequestCode;
                readyReg  <= 1'b0;
            end

            // A marker always restarts the shift sequence for the new second, even mid-sequence.
            if (ppsEdge) begin
                state   <= ST_SHIFT;
                bitIdx  <= BIT_TOP;
                spacing <= SPC_TOP;
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (spacing == '0) begin
                            spacing <= SPC_TOP;
                            if (bitIdx == '0) begin
                                state <= ST_DONE;
                            end else begin
                                bitIdx <= bitIdx - 1'b1;
                            end
                        end else begin
                            spacing <= spacing - 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
